mix_columns_iter: RTL
=====================

MIX_COLUMNS_ITER -- requirements
Module: mix_columns_iter

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, default 1: columns transformed per RUN cycle; legal values 1, 2, 4.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  input state offered.
REQ-005 SHALL have port in_ready  output  1  block can accept a state.
REQ-006 SHALL have port in_data  input  128  AES state; column c at [127-32c -: 32]; row r byte at [127-32c-8r -: 8].
REQ-007 SHALL have port inv  input  1  0 = MixColumns, 1 = InvMixColumns; sampled with in_data.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port out_data  output  128  transformed state, same byte layout as in_data.
REQ-011 SHALL have port busy  output  1  high in RUN or DONE.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; NCYC = 4/COLS_PER_CYCLE.
REQ-013 IDLE: in_ready=1, out_valid=0; when in_valid is high at an edge, SHALL latch in_data and inv, clear column counter, go to RUN.
REQ-014 RUN: each edge SHALL replace COLS_PER_CYCLE columns, lowest unprocessed index first, with their transform, and advance the counter by COLS_PER_CYCLE.
REQ-015 RUN: after the edge processing column 3, SHALL go to DONE; out_valid rises exactly NCYC edges after the acceptance edge.
REQ-016 DONE: out_valid=1; out_data and out_valid SHALL hold stable while out_ready=0; on an edge with out_ready=1, SHALL go to IDLE.
REQ-017 in_ready SHALL be 1 only in IDLE; in_valid outside IDLE SHALL be ignored; no input/output overlap.
REQ-018 Forward transform per column SHALL be the FIPS-197 matrix {02,03,01,01} circulant over GF(2^8), reduction polynomial 0x11B.
REQ-019 Inverse transform SHALL be the circulant {0e,0b,0d,09} over the same field.
REQ-020 inv SHALL be sampled only at acceptance; changes during RUN/DONE SHALL have no effect.
REQ-021 out_data SHALL reflect the working register only; unprocessed columns are never visible with out_valid=1.
REQ-022 An illegal COLS_PER_CYCLE SHALL cause elaboration failure.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, counter 0, working register 0, out_valid=0, busy=0, out_data=0; in_ready=1 once reset is released.
REQ-024 Reset asserted in RUN or DONE SHALL discard the in-flight state; the first operation after reset release behaves as from power-up.

Configuration
REQ-025 Macro MIX_COLUMNS_INV_EN defined: inv port and InvMixColumns datapath SHALL be present per REQ-019.
REQ-026 Macro undefined: inv port SHALL still exist but be ignored, only the forward transform is built, and inverse-mode results are forward results.

Verification
REQ-027 COLS_PER_CYCLE=1, inv=0, in_data=db135345f20a225c010101012d26314c -> out_data=8e4da1bc9fdc589d010101014d7ebdf8, out_valid rises 4 edges after acceptance.
REQ-028 MIX_COLUMNS_INV_EN defined, inv=1, in_data=8e4da1bc9fdc589d010101014d7ebdf8 -> out_data=db135345f20a225c010101012d26314c; repeat with COLS_PER_CYCLE=2 (2 edges) and 4 (1 edge).
REQ-029 out_ready held 0 for 5 cycles in DONE -> out_valid and out_data stable; in_ready=0; in_valid pulses ignored; accept proceeds only after out_ready=1 returns FSM to IDLE.
REQ-030 in_data=c6c6c6c6d4d4d4d5_c6c6c6c6d4d4d4d5 -> out_data=c6c6c6c6d5d5d7d6_c6c6c6c6d5d5d7d6; inv toggled mid-RUN leaves result unchanged.
REQ-031 rst_n pulsed low during RUN (counter=2) -> out_valid=0, busy=0, out_data=0 immediately; next vector completes correctly.
REQ-032 Back-to-back: out_valid and out_ready high, in_valid held high -> new state accepted on the edge after DONE->IDLE; throughput one state per NCYC+2 cycles.

Source files
------------

// File: rtl/mix_columns_iter.sv
// mix_columns_iter: iterative AES (Inv)MixColumns, COLS_PER_CYCLE columns per RUN cycle.
// Define MIX_COLUMNS_INV_EN to build the InvMixColumns datapath; otherwise inv is ignored.
module mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam logic [2:0] STEP = 3'(COLS_PER_CYCLE);
  state_e       state_q;
  logic [2:0]   cnt_q;
  logic [127:0] data_q, data_d;
  logic         in_ready_q, out_valid_q, busy_q;
  logic         inv_eff;
  logic         last;
  logic [1:0]   idx;
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  // m[j][i] is byte i scaled by the j-th coefficient of the circulant row
  function automatic logic [31:0] mix_col(input logic [31:0] c, input logic iv);
    logic [7:0] m [4][4];
    logic [7:0] b, p2, p4, p8;
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      b  = c[31-8*i -: 8];
      p2 = xt(b);
      p4 = xt(p2);
      p8 = xt(p4);
      m[0][i] = iv ? p8 ^ p4 ^ p2 : p2;
      m[1][i] = iv ? p8 ^ p2 ^ b  : p2 ^ b;
      m[2][i] = iv ? p8 ^ p4 ^ b  : b;
      m[3][i] = iv ? p8 ^ b       : b;
    end
    for (int k = 0; k < 4; k++)
      r[31-8*k -: 8] = m[0][k] ^ m[1][(k+1)%4] ^ m[2][(k+2)%4] ^ m[3][(k+3)%4];
    return r;
  endfunction
`ifdef MIX_COLUMNS_INV_EN
  logic inv_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) inv_q <= 1'b0;
    else if (state_q == IDLE && in_valid) inv_q <= inv;
  assign inv_eff = inv_q;
`else
  logic unused_inv;
  assign unused_inv = inv;
  assign inv_eff    = 1'b0;
`endif
  assign last = (cnt_q + STEP) == 3'd4;
  always_comb begin
    data_d = data_q;
    idx    = '0;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      idx = cnt_q[1:0] + 2'(k);
      data_d[127-32*int'(idx) -: 32] = mix_col(data_q[127-32*int'(idx) -: 32], inv_eff);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      data_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          state_q    <= RUN;
          cnt_q      <= '0;
          data_q     <= in_data;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b1;
        end
        RUN: begin
          data_q <= data_d;
          cnt_q  <= cnt_q + STEP;
          if (last) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = data_q;
endmodule
